countdown_timer60: RTL
======================

Name: countdown_timer60

Overview:
- mm:ss countdown timer built from two chained mod-60 down-counters. Seconds borrow into minutes.
- Counts down one second per `tick` strobe from a loaded preset to 00:00.
- At 00:00 it pulses `done` and holds `alarm` high for a fixed number of ticks.
- Sits beside the up-counting clock chain and shares its 1 Hz tick strobe and 6-bit binary digit format.

Parameters:
- ALARM_TICKS, 4: number of tick strobes `alarm` stays high after reaching 00:00. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle enable strobe (1 Hz class); ignored unless noted.
- ld  in  1  load preset; highest priority after reset.
- d_min  in  6  preset minutes, binary.
- d_sec  in  6  preset seconds, binary.
- start  in  1  start/resume/acknowledge pulse.
- stop  in  1  pause/acknowledge pulse.
- min  out  6  current minutes, binary 0..59.
- sec  out  6  current seconds, binary 0..59.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the count reaches 00:00.
- alarm  out  1  high while in ALARM.

Behaviour:
- Reset (rst=0, async): state IDLE, min=0, sec=0, running=0, done=0, alarm=0, alarm tick count=0.
- Priority each clock: ld > stop > start > tick.
- ld (any state):
  - min <= min(d_min,59), sec <= min(d_sec,59); values above 59 clamp to 59.
  - State -> IDLE; alarm and done cleared next cycle.
- IDLE:
  - start with (min,sec) != 00:00 -> RUN.
  - start at 00:00 is ignored.
  - tick and stop have no effect.
- RUN:
  - stop -> PAUSE; a tick in the same cycle is discarded.
  - Else, on tick: if sec != 0 then sec <= sec-1. If sec == 0 then sec <= 59 and min <= min-1 (borrow).
  - Tick with count 00:01 -> count 00:00, state ALARM, done=1 for exactly that following cycle.
  - Count never wraps below 00:00; RUN never holds 00:00.
  - A start during RUN is ignored.
- PAUSE:
  - start -> RUN; ticks resume counting from the next cycle.
  - tick and stop are ignored; count is held.
- ALARM:
  - alarm=1; each tick increments the alarm count.
  - When ALARM_TICKS ticks have been counted, state -> IDLE and alarm=0 on that edge.
  - start or stop -> IDLE immediately (acknowledge); alarm count cleared.
  - min and sec stay 00:00.
- Outputs are registered or pure decodes of state. `running` = (state==RUN). `alarm` = (state==ALARM).
- Simultaneous start and stop: stop wins (RUN->PAUSE, PAUSE stays, ALARM->IDLE).
- Reset mid-count: everything returns to reset values asynchronously; no done pulse.

Decomposition:
- Shared header of `define constants: SEC_MAX = 6'd59 and state encodings IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3.
- One sub-module, down_counter60, instantiated twice.
  - Ports: clk, rst, ld, d[5:0], bi, bo, q[5:0].
  - q <= d on ld. Else, on bi: q==0 -> 59, else q-1.
  - bo = (q==0 && bi), combinational.
  - Seconds instance: bi = tick & RUN & ~stop. Minutes instance: bi = seconds bo.
  - Clamping and zero detect live in the top level.

Test Plan:
- Reset check: assert rst=0 mid-run at 02:17 -> min=0, sec=0, running=0, alarm=0 immediately, no done pulse.
- Borrow: load 01:00, start, one tick -> 00:59. Load 10:00, start, 600 ticks -> done pulses once after the 600th tick; state ALARM.
- Clamp: ld with d_min=63, d_sec=60 -> min=59, sec=59, state IDLE.
- Start at 00:00 -> running stays 0. Load 00:03, start, 3 ticks -> done one cycle, alarm=1.
  - 4 more ticks (ALARM_TICKS=4) -> alarm=0, IDLE.
- Pause and priority: at 00:30 in RUN, stop and tick in the same cycle -> PAUSE, count 00:30. Further ticks hold the count. Start -> RUN, next tick gives 00:29.
- Acknowledge: in ALARM after 1 tick, start pulse -> IDLE, alarm=0 next cycle. ld during RUN at 05:05 with 00:10 -> IDLE at 00:10.

Source files
------------

// File: rtl/countdown_timer60_pkg.sv
// Shared constants, state encoding and preset clamp for the mm:ss countdown timer.
package countdown_timer60_pkg;

  localparam logic [5:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  // Presets above 59 saturate rather than wrap.
  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > SEC_MAX) ? SEC_MAX : v;
  endfunction

endpackage

// File: rtl/countdown_timer60_down_counter60.sv
// Mod-60 down-counter digit with borrow-in / borrow-out, used for seconds and minutes.
module down_counter60
  import countdown_timer60_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [5:0] d,
  input  logic       bi,
  output logic       bo,
  output logic [5:0] q
);

  // Load has priority; otherwise a borrow-in decrements, wrapping 0 -> 59.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (ld)  q <= d;
    else if (bi)  q <= (q == 6'd0) ? SEC_MAX : q - 6'd1;
  end

  assign bo = (q == 6'd0) && bi;

endmodule

// File: rtl/countdown_timer60.sv
// mm:ss countdown timer: two chained mod-60 digits plus IDLE/RUN/PAUSE/ALARM control.
module countdown_timer60
  import countdown_timer60_pkg::*;
#(
  parameter int ALARM_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ld,
  input  logic [5:0] d_min,
  input  logic [5:0] d_sec,
  input  logic       start,
  input  logic       stop,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  state_t     state, nstate;
  logic [3:0] acnt, nacnt;
  logic       ndone;
  logic       sec_bi, sec_bo, min_bo;
  logic       zero, last_sec;

  // Digits only move on a tick that RUN actually accepts; stop and ld both claim the cycle.
  assign sec_bi   = tick & (state == RUN) & ~stop & ~ld;
  assign zero     = (min == 6'd0) && (sec == 6'd0);
  assign last_sec = sec_bi && (min == 6'd0) && (sec == 6'd1);

  down_counter60 u_sec (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .d   (clamp59(d_sec)),
    .bi  (sec_bi),
    .bo  (sec_bo),
    .q   (sec)
  );

  down_counter60 u_min (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .d   (clamp59(d_min)),
    .bi  (sec_bo),
    .bo  (min_bo),
    .q   (min)
  );

  // Control state, alarm tick count and the done pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acnt  <= '0;
      done  <= 1'b0;
    end else begin
      state <= nstate;
      acnt  <= nacnt;
      done  <= ndone;
    end
  end

  // Next state: ld > stop > start > tick. A stop in IDLE swallows a simultaneous start.
  always_comb begin
    nstate = state;
    nacnt  = acnt;
    ndone  = 1'b0;
    if (ld) begin
      nstate = IDLE;
      nacnt  = '0;
    end else begin
      case (state)
        IDLE:  if (start && !stop && !zero) nstate = RUN;
        RUN: begin
          if (stop) nstate = PAUSE;
          else if (last_sec) begin
            nstate = ALARM;
            ndone  = 1'b1;
            nacnt  = '0;
          end
        end
        PAUSE: if (!stop && start) nstate = RUN;
        ALARM: begin
          if (stop || start) begin
            nstate = IDLE;
            nacnt  = '0;
          end else if (tick) begin
            if (acnt == 4'(ALARM_TICKS - 1)) begin
              nstate = IDLE;
              nacnt  = '0;
            end else begin
              nacnt = acnt + 4'd1;
            end
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign alarm   = (state == ALARM);

endmodule
